// File: rtl/vend_txn_fsm.sv
// vend_txn_fsm -- purchase-transaction controller for the vending datapath.
//
// Takes an item selection, reads cost/stock from the item memory over the
// fsm_read_* handshake, accumulates inserted currency, then dispenses,
// decrements stock over fsm_update_* and returns change. Cancel and an
// inactivity timeout end the transaction with a refund of the held credit.
//
// Ports:
//   clk_fsm, rst                     clock, synchronous active-high reset
//   item_select_valid/_id            selection strobe and item id
//   currency_valid/_value            coin/note strobe and value (cost units)
//   cancel                           user cancel strobe
//   fsm_read_en/_addr                memory read request (one cycle)
//   fsm_item_cost/_available         read data, qualified by fsm_data_valid
//   fsm_update_en/_addr              stock-decrement request (one cycle)
//   dispense_valid/_item             dispense pulse and item
//   change_valid/_value              change/refund pulse and amount
//   coin_reject                      currency returned unaccepted
//   txn_done/txn_status              end-of-transaction pulse and result
//   busy                             high whenever not idle
// All outputs are registered.
module vend_txn_fsm #(
    parameter int MAX_ITEMS      = 1024,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk_fsm,
    input  logic                  rst,
    input  logic                  item_select_valid,
    input  logic [ADDR_WIDTH-1:0] item_select_id,
    input  logic                  currency_valid,
    input  logic [7:0]            currency_value,
    input  logic                  cancel,
    output logic                  fsm_read_en,
    output logic [ADDR_WIDTH-1:0] fsm_read_addr,
    input  logic [15:0]           fsm_item_cost,
    input  logic [7:0]            fsm_item_available,
    input  logic                  fsm_data_valid,
    output logic                  fsm_update_en,
    output logic [ADDR_WIDTH-1:0] fsm_update_addr,
    output logic                  dispense_valid,
    output logic [ADDR_WIDTH-1:0] dispense_item,
    output logic                  change_valid,
    output logic [15:0]           change_value,
    output logic                  coin_reject,
    output logic                  txn_done,
    output logic [2:0]            txn_status,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_DATA, S_COLLECT, S_VEND, S_CHANGE, S_DONE
    } state_t;

    localparam logic [2:0] ST_VENDED    = 3'd0;
    localparam logic [2:0] ST_SOLD_OUT  = 3'd1;
    localparam logic [2:0] ST_BAD_ID    = 3'd2;
    localparam logic [2:0] ST_CANCELLED = 3'd3;
    localparam logic [2:0] ST_TIMEOUT   = 3'd4;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    // One extra bit so MAX_ITEMS == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] ID_LIMIT = (ADDR_WIDTH + 1)'(MAX_ITEMS);

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] item_id, item_id_d;
    logic [15:0]           cost, cost_d;
    logic [15:0]           credit, credit_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [2:0]            reason, reason_d;   // status carried through CHANGE

    logic [ADDR_WIDTH-1:0] read_addr_d, update_addr_d, disp_item_d;
    logic [15:0]           chg_val_d;
    logic                  rej_d;
    logic [2:0]            status_d;
    logic [16:0]           sum;
    logic                  coin_ok;

    always_comb begin
        state_d   = state;
        item_id_d = item_id;
        cost_d    = cost;
        credit_d  = credit;
        cnt_d     = cnt;
        reason_d  = reason;
        chg_val_d = change_value;
        status_d  = txn_status;
        // Currency is only ever taken in COLLECT; everywhere else it bounces.
        rej_d     = currency_valid && (state != S_COLLECT);
        sum       = {1'b0, credit} + 17'(currency_value);
        coin_ok   = currency_valid && !sum[16];

        case (state)
            S_IDLE: begin
                if (item_select_valid) begin
                    if ({1'b0, item_select_id} < ID_LIMIT) begin
                        item_id_d = item_select_id;
                        state_d   = S_FETCH;
                    end else begin
                        state_d  = S_DONE;
                        status_d = ST_BAD_ID;
                    end
                end
            end
            S_FETCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (fsm_data_valid) begin
                    cost_d = fsm_item_cost;
                    cnt_d  = '0;
                    if (fsm_item_available == 8'd0) begin
                        state_d  = S_DONE;
                        status_d = ST_SOLD_OUT;
                    end else if (fsm_item_cost == 16'd0) begin
                        state_d  = S_VEND;
                        reason_d = ST_VENDED;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_COLLECT: begin
                // cancel > coin > timeout
                if (cancel) begin
                    state_d   = S_CHANGE;
                    reason_d  = ST_CANCELLED;
                    chg_val_d = credit;
                    rej_d     = currency_valid;
                end else if (coin_ok) begin
                    credit_d = sum[15:0];
                    cnt_d    = '0;
                    if (sum[15:0] >= cost) begin
                        state_d  = S_VEND;
                        reason_d = ST_VENDED;
                    end
                end else begin
                    // Overflowing coin: returned, and it does not count as activity.
                    rej_d = currency_valid;
                    if (cnt == CNT_LAST) begin
                        state_d   = S_CHANGE;
                        reason_d  = ST_TIMEOUT;
                        chg_val_d = credit;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            S_VEND: begin
                state_d   = S_CHANGE;
                chg_val_d = credit - cost;   // credit >= cost is guaranteed here
            end
            S_CHANGE: begin
                credit_d = '0;
                state_d  = S_DONE;
                status_d = reason;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // FETCH/VEND/CHANGE/DONE each last exactly one cycle, so their pulse
        // outputs are simply "next state is X", registered.
        read_addr_d   = (state_d == S_FETCH) ? item_id_d : fsm_read_addr;
        update_addr_d = (state_d == S_VEND)  ? item_id_d : fsm_update_addr;
        disp_item_d   = (state_d == S_VEND)  ? item_id_d : dispense_item;
    end

    always_ff @(posedge clk_fsm) begin
        if (rst) begin
            state           <= S_IDLE;
            item_id         <= '0;
            cost            <= '0;
            credit          <= '0;
            cnt             <= '0;
            reason          <= '0;
            fsm_read_en     <= 1'b0;
            fsm_read_addr   <= '0;
            fsm_update_en   <= 1'b0;
            fsm_update_addr <= '0;
            dispense_valid  <= 1'b0;
            dispense_item   <= '0;
            change_valid    <= 1'b0;
            change_value    <= '0;
            coin_reject     <= 1'b0;
            txn_done        <= 1'b0;
            txn_status      <= '0;
            busy            <= 1'b0;
        end else begin
            state           <= state_d;
            item_id         <= item_id_d;
            cost            <= cost_d;
            credit          <= credit_d;
            cnt             <= cnt_d;
            reason          <= reason_d;
            fsm_read_en     <= (state_d == S_FETCH);
            fsm_read_addr   <= read_addr_d;
            fsm_update_en   <= (state_d == S_VEND);
            fsm_update_addr <= update_addr_d;
            dispense_valid  <= (state_d == S_VEND);
            dispense_item   <= disp_item_d;
            change_valid    <= (state_d == S_CHANGE);
            change_value    <= chg_val_d;
            coin_reject     <= rej_d;
            txn_done        <= (state_d == S_DONE);
            txn_status      <= status_d;
            busy            <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_vend_txn_fsm.sv
// Directed bench for vend_txn_fsm with a small item-memory model that answers
// reads one cycle after fsm_read_en and decrements stock on fsm_update_en.
// Inputs are driven and outputs sampled on the falling edge.
module tb_vend_txn_fsm;

    localparam int AW = 11;   // wide enough to present id 1024
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          isv, cv, cancel;
    logic [AW-1:0] isid;
    logic [7:0]    cval;
    logic          fsm_read_en, fsm_update_en, fsm_data_valid;
    logic [AW-1:0] fsm_read_addr, fsm_update_addr, dispense_item;
    logic [15:0]   fsm_item_cost, change_value;
    logic [7:0]    fsm_item_available;
    logic          dispense_valid, change_valid, coin_reject, txn_done, busy;
    logic [2:0]    txn_status;

    int tests = 0, fails = 0;
    int n_rd = 0, n_upd = 0, n_dsp = 0, n_chg = 0;
    int c_rd, c_upd, c_dsp, c_chg;
    logic mute = 1'b0;

    logic [15:0] cost_tbl [0:15] = '{16'd0, 16'd10, 16'd200, 16'hFFFF, 16'd0, 16'd150, 16'd0, 16'd40,
                                     16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [7:0]  avail_tbl [0:15] = '{8'd0, 8'd1, 8'd5, 8'd1, 8'd1, 8'd3, 8'd0, 8'd0,
                                      8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    always #5 clk = ~clk;

    vend_txn_fsm #(.MAX_ITEMS(1024), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_fsm(clk), .rst(rst),
        .item_select_valid(isv), .item_select_id(isid),
        .currency_valid(cv), .currency_value(cval), .cancel(cancel),
        .fsm_read_en(fsm_read_en), .fsm_read_addr(fsm_read_addr),
        .fsm_item_cost(fsm_item_cost), .fsm_item_available(fsm_item_available),
        .fsm_data_valid(fsm_data_valid),
        .fsm_update_en(fsm_update_en), .fsm_update_addr(fsm_update_addr),
        .dispense_valid(dispense_valid), .dispense_item(dispense_item),
        .change_valid(change_valid), .change_value(change_value),
        .coin_reject(coin_reject), .txn_done(txn_done), .txn_status(txn_status),
        .busy(busy)
    );

    // Item memory model plus pulse counters.
    always @(posedge clk) begin
        fsm_data_valid <= 1'b0;
        if (fsm_read_en && !mute) begin
            fsm_data_valid     <= 1'b1;
            fsm_item_cost      <= cost_tbl[fsm_read_addr[3:0]];
            fsm_item_available <= avail_tbl[fsm_read_addr[3:0]];
        end
        if (fsm_update_en) avail_tbl[fsm_update_addr[3:0]] <= avail_tbl[fsm_update_addr[3:0]] - 8'd1;
        if (fsm_read_en)    n_rd  <= n_rd + 1;
        if (fsm_update_en)  n_upd <= n_upd + 1;
        if (dispense_valid) n_dsp <= n_dsp + 1;
        if (change_valid)   n_chg <= n_chg + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic snap();
        c_rd = n_rd; c_upd = n_upd; c_dsp = n_dsp; c_chg = n_chg;
    endtask

    // Drive a selection and advance to N+3 (COLLECT for a priced in-stock item).
    task automatic select_to_collect(input logic [AW-1:0] id);
        isv = 1'b1; isid = id; step(); isv = 1'b0; step(); step();
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); step();
        tests++; if ({busy, fsm_read_en, fsm_update_en, dispense_valid, change_valid, coin_reject, txn_done} !== 7'b0) begin
            fails++; $display("FAIL reset_pulses: got %b expected 0", {busy, fsm_read_en, fsm_update_en, dispense_valid, change_valid, coin_reject, txn_done}); end
        tests++; if ({txn_status, change_value, dispense_item, fsm_read_addr} !== '0) begin
            fails++; $display("FAIL reset_values: status %0d change %0h item %0h addr %0h expected all 0", txn_status, change_value, dispense_item, fsm_read_addr); end
        rst = 1'b0; step();
    endtask

    task automatic test_vend();
        snap();
        isv = 1'b1; isid = 5; step();                        // N+1
        isv = 1'b0;
        tests++; if (fsm_read_en !== 1'b1 || fsm_read_addr !== 11'd5 || busy !== 1'b1) begin
            fails++; $display("FAIL vend_fetch: rd %b addr %0d busy %b expected 1 5 1", fsm_read_en, fsm_read_addr, busy); end
        cv = 1'b1; cval = 30; isv = 1'b1; isid = 6; step();   // coin + stray select in FETCH
        cv = 1'b0; isv = 1'b0;
        tests++; if (coin_reject !== 1'b1 || fsm_read_en !== 1'b0) begin
            fails++; $display("FAIL vend_fetch_coin: rej %b rd %b expected 1 0", coin_reject, fsm_read_en); end
        step();                                              // N+3 COLLECT
        cv = 1'b1; cval = 100; step(); step(); cv = 1'b0;    // M+1
        tests++; if (dispense_valid !== 1'b1 || dispense_item !== 11'd5 || fsm_update_en !== 1'b1 || fsm_update_addr !== 11'd5) begin
            fails++; $display("FAIL vend_dispense: dv %b item %0d up %b addr %0d expected 1 5 1 5", dispense_valid, dispense_item, fsm_update_en, fsm_update_addr); end
        step();
        tests++; if (change_valid !== 1'b1 || change_value !== 16'd50) begin
            fails++; $display("FAIL vend_change: cv %b val %0d expected 1 50", change_valid, change_value); end
        step();
        tests++; if (txn_done !== 1'b1 || txn_status !== 3'd0) begin
            fails++; $display("FAIL vend_done: done %b status %0d expected 1 0", txn_done, txn_status); end
        step();
        tests++; if (busy !== 1'b0 || avail_tbl[5] !== 8'd2 || n_dsp - c_dsp != 1 || n_upd - c_upd != 1 || n_rd - c_rd != 1) begin
            fails++; $display("FAIL vend_after: busy %b avail %0d dsp %0d upd %0d rd %0d expected 0 2 1 1 1", busy, avail_tbl[5], n_dsp - c_dsp, n_upd - c_upd, n_rd - c_rd); end
    endtask

    task automatic test_cost_zero();
        select_to_collect(4);                                // N+3 is VEND here
        tests++; if (dispense_valid !== 1'b1 || dispense_item !== 11'd4) begin
            fails++; $display("FAIL free_dispense: dv %b item %0d expected 1 4", dispense_valid, dispense_item); end
        step();
        tests++; if (change_valid !== 1'b1 || change_value !== 16'd0) begin
            fails++; $display("FAIL free_change: cv %b val %0d expected 1 0", change_valid, change_value); end
        step();
        tests++; if (txn_done !== 1'b1 || txn_status !== 3'd0) begin
            fails++; $display("FAIL free_done: done %b status %0d expected 1 0", txn_done, txn_status); end
        step();
    endtask

    task automatic test_sold_out();
        snap();
        isv = 1'b1; isid = 7; step(); isv = 1'b0; step();     // N+2
        tests++; if (txn_done !== 1'b0) begin
            fails++; $display("FAIL soldout_early: done %b expected 0", txn_done); end
        step();                                              // N+3
        tests++; if (txn_done !== 1'b1 || txn_status !== 3'd1) begin
            fails++; $display("FAIL soldout_done: done %b status %0d expected 1 1", txn_done, txn_status); end
        step();
        tests++; if (n_dsp != c_dsp || n_chg != c_chg || n_upd != c_upd || n_rd - c_rd != 1 || busy !== 1'b0) begin
            fails++; $display("FAIL soldout_pulses: dsp %0d chg %0d upd %0d rd %0d busy %b expected 0 0 0 1 0", n_dsp - c_dsp, n_chg - c_chg, n_upd - c_upd, n_rd - c_rd, busy); end
    endtask

    task automatic test_bad_id();
        snap();
        isv = 1'b1; isid = 11'd1024; step(); isv = 1'b0;      // N+1
        tests++; if (txn_done !== 1'b1 || txn_status !== 3'd2) begin
            fails++; $display("FAIL badid_done: done %b status %0d expected 1 2", txn_done, txn_status); end
        step();
        tests++; if (busy !== 1'b0 || n_rd != c_rd) begin
            fails++; $display("FAIL badid_noread: busy %b reads %0d expected 0 0", busy, n_rd - c_rd); end
    endtask

    task automatic test_cancel();
        snap();
        select_to_collect(2);
        cv = 1'b1; cval = 50; step();
        cval = 20; cancel = 1'b1; step();                    // C+1
        cv = 1'b0; cancel = 1'b0;
        tests++; if (change_valid !== 1'b1 || change_value !== 16'd50 || coin_reject !== 1'b1) begin
            fails++; $display("FAIL cancel_refund: cv %b val %0d rej %b expected 1 50 1", change_valid, change_value, coin_reject); end
        step();
        tests++; if (txn_done !== 1'b1 || txn_status !== 3'd3 || n_dsp != c_dsp) begin
            fails++; $display("FAIL cancel_done: done %b status %0d dsp %0d expected 1 3 0", txn_done, txn_status, n_dsp - c_dsp); end
        step();
    endtask

    task automatic test_timeout();
        select_to_collect(2);
        cv = 1'b1; cval = 10; step(); cv = 1'b0;             // K+1
        repeat (TO - 1) step();                              // K+TO
        tests++; if (change_valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL timeout_early: cv %b busy %b expected 0 1", change_valid, busy); end
        step();
        tests++; if (change_valid !== 1'b1 || change_value !== 16'd10) begin
            fails++; $display("FAIL timeout_refund: cv %b val %0d expected 1 10", change_valid, change_value); end
        step();
        tests++; if (txn_done !== 1'b1 || txn_status !== 3'd4) begin
            fails++; $display("FAIL timeout_done: done %b status %0d expected 1 4", txn_done, txn_status); end
        step();
        cv = 1'b1; cval = 25; step(); cv = 1'b0;
        tests++; if (coin_reject !== 1'b1 || busy !== 1'b0 || change_valid !== 1'b0) begin
            fails++; $display("FAIL idle_coin: rej %b busy %b cv %b expected 1 0 0", coin_reject, busy, change_valid); end
        step();
        tests++; if (coin_reject !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL idle_coin_after: rej %b busy %b expected 0 0", coin_reject, busy); end
    endtask

    task automatic test_wait_timeout();
        snap();
        mute = 1'b1;
        isv = 1'b1; isid = 1; step(); isv = 1'b0;            // N+1
        repeat (TO) step();                                  // N+1+TO
        tests++; if (txn_done !== 1'b0) begin
            fails++; $display("FAIL waitto_early: done %b expected 0", txn_done); end
        step();
        tests++; if (txn_done !== 1'b1 || txn_status !== 3'd4) begin
            fails++; $display("FAIL waitto_done: done %b status %0d expected 1 4", txn_done, txn_status); end
        mute = 1'b0; step();
        tests++; if (n_chg != c_chg || busy !== 1'b0) begin
            fails++; $display("FAIL waitto_norefund: chg %0d busy %b expected 0 0", n_chg - c_chg, busy); end
    endtask

    task automatic test_reset_mid();
        snap();
        select_to_collect(2);
        cv = 1'b1; cval = 50; step(); cv = 1'b0;
        rst = 1'b1; step();
        tests++; if ({busy, change_valid, txn_done, coin_reject, dispense_valid} !== 5'b0 || txn_status !== 3'd0) begin
            fails++; $display("FAIL midrst_out: flags %b status %0d expected 0 0", {busy, change_valid, txn_done, coin_reject, dispense_valid}, txn_status); end
        rst = 1'b0; step(); step(); step();
        tests++; if (n_chg != c_chg || busy !== 1'b0) begin
            fails++; $display("FAIL midrst_nochange: chg %0d busy %b expected 0 0", n_chg - c_chg, busy); end
    endtask

    task automatic test_overflow();
        select_to_collect(3);                                // cost 0xFFFF
        cv = 1'b1; cval = 8'd255;
        repeat (256) step();                                 // 0xFF00
        cval = 8'd240; step();                               // 0xFFF0
        cval = 8'h20; step(); cv = 1'b0;                     // would exceed 0xFFFF
        tests++; if (coin_reject !== 1'b1 || dispense_valid !== 1'b0) begin
            fails++; $display("FAIL ovf_reject: rej %b dv %b expected 1 0", coin_reject, dispense_valid); end
        cv = 1'b1; cval = 8'h0F; step(); cv = 1'b0;          // exactly 0xFFFF
        tests++; if (dispense_valid !== 1'b1 || dispense_item !== 11'd3 || coin_reject !== 1'b0) begin
            fails++; $display("FAIL ovf_vend: dv %b item %0d rej %b expected 1 3 0", dispense_valid, dispense_item, coin_reject); end
        step();
        tests++; if (change_valid !== 1'b1 || change_value !== 16'd0) begin
            fails++; $display("FAIL ovf_change: cv %b val %0h expected 1 0", change_valid, change_value); end
        step();
        tests++; if (txn_done !== 1'b1 || txn_status !== 3'd0 || avail_tbl[3] !== 8'd0) begin
            fails++; $display("FAIL ovf_done: done %b status %0d avail %0d expected 1 0 0", txn_done, txn_status, avail_tbl[3]); end
        step();
    endtask

    initial begin
        rst = 1'b1; isv = 1'b0; isid = '0; cv = 1'b0; cval = '0; cancel = 1'b0;
        test_reset();
        test_vend();
        test_cost_zero();
        test_sold_out();
        test_bad_id();
        test_cancel();
        test_timeout();
        test_wait_timeout();
        test_reset_mid();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
